// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
//
// Two-requester Avalon-MM arbiter in front of a single-port on-chip RAM with a
// one-cycle read latency. Requester r0 is normally the CPU data master and r1
// a secondary master (DMA, debug loader). At most one access is issued per
// cycle. The owner of the outstanding read is remembered so the returned data
// is flagged valid only for the requester that asked for it.
//
// Arbitration:
//   PRIO_MODE = 0 : round-robin; on a tie the requester not granted last wins.
//   PRIO_MODE = 1 : r0 wins ties, except that r1 is granted once r0 has won
//                   STARVE_LIMIT consecutive ties against it.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   r0_* / r1_*           Avalon-MM slave ports (address, byteenable, read,
//                         write, writedata, waitrequest, readdata,
//                         readdatavalid)
//   mem_*                 RAM port (address, byteenable, chipselect, write,
//                         writedata, readdata - valid one cycle after issue)
// -----------------------------------------------------------------------------
module onchip_mem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int PRIO_MODE    = 0,
  parameter int STARVE_LIMIT = 4,
  localparam int BE_W        = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic [ADDR_W-1:0] r0_address,
  input  logic [BE_W-1:0]   r0_byteenable,
  input  logic              r0_read,
  input  logic              r0_write,
  input  logic [DATA_W-1:0] r0_writedata,
  output logic              r0_waitrequest,
  output logic [DATA_W-1:0] r0_readdata,
  output logic              r0_readdatavalid,

  input  logic [ADDR_W-1:0] r1_address,
  input  logic [BE_W-1:0]   r1_byteenable,
  input  logic              r1_read,
  input  logic              r1_write,
  input  logic [DATA_W-1:0] r1_writedata,
  output logic              r1_waitrequest,
  output logic [DATA_W-1:0] r1_readdata,
  output logic              r1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata
);

  typedef enum logic {
    OWN_R0 = 1'b0,
    OWN_R1 = 1'b1
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  // State
  logic       ready_q,      ready_d;
  owner_e     last_grant_q, last_grant_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       rd_pend_q,    rd_pend_d;
  owner_e     rd_owner_q,   rd_owner_d;

  // Request decode; a simultaneous read+write is treated as a write.
  logic req0, req1;
  logic is_rd0, is_rd1;
  logic gnt0, gnt1;

  assign req0   = r0_read | r0_write;
  assign req1   = r1_read | r1_write;
  assign is_rd0 = r0_read & ~r0_write;
  assign is_rd1 = r1_read & ~r1_write;

  // ---------------------------------------------------------------------------
  // Grant decision
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default first, so
  // no path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (ready_q) begin
      if (req0 && !req1) begin
        gnt0 = 1'b1;
      end else if (req1 && !req0) begin
        gnt1 = 1'b1;
      end else if (req0 && req1) begin
        if (PRIO_MODE == 0) begin
          if (last_grant_q == OWN_R0) gnt1 = 1'b1;
          else                        gnt0 = 1'b1;
        end else begin
          if (starve_cnt_q == LIMIT) gnt1 = 1'b1;
          else                       gnt0 = 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Issue path: the winner's request goes straight to the RAM this cycle.
  // When idle the address/data mux rests on r0.
  // ---------------------------------------------------------------------------
  assign r0_waitrequest = ~gnt0;
  assign r1_waitrequest = ~gnt1;

  assign mem_chipselect = gnt0 | gnt1;
  assign mem_write      = (gnt0 & r0_write) | (gnt1 & r1_write);
  assign mem_address    = gnt1 ? r1_address    : r0_address;
  assign mem_byteenable = gnt1 ? r1_byteenable : r0_byteenable;
  assign mem_writedata  = gnt1 ? r1_writedata  : r0_writedata;

  // Read return: data is shared, the valid strobe is steered by the owner
  // recorded when the read was issued.
  assign r0_readdata      = mem_readdata;
  assign r1_readdata      = mem_readdata;
  assign r0_readdatavalid = rd_pend_q & (rd_owner_q == OWN_R0);
  assign r1_readdatavalid = rd_pend_q & (rd_owner_q == OWN_R1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_d      = 1'b1;
    last_grant_d = last_grant_q;
    starve_cnt_d = starve_cnt_q;
    rd_pend_d    = 1'b0;
    rd_owner_d   = rd_owner_q;

    if (gnt0)      last_grant_d = OWN_R0;
    else if (gnt1) last_grant_d = OWN_R1;

    // Counts r0 wins while r1 is kept waiting; any r1 service or a gap in
    // r1's request restarts the count.
    if (!req1 || gnt1) begin
      starve_cnt_d = '0;
    end else if (gnt0 && (starve_cnt_q < LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (gnt0 && is_rd0) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = OWN_R0;
    end else if (gnt1 && is_rd1) begin
      rd_pend_d  = 1'b1;
      rd_owner_d = OWN_R1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers. The asynchronous reset also drops a read that is in
  // flight, so it can never produce a readdatavalid after reset.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q      <= 1'b0;
      last_grant_q <= OWN_R1;
      starve_cnt_q <= '0;
      rd_pend_q    <= 1'b0;
      rd_owner_q   <= OWN_R0;
    end else begin
      ready_q      <= ready_d;
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      rd_pend_q    <= rd_pend_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_onchip_mem_arbiter
//
// Drives one round-robin instance and one priority instance with the same
// request stream. Each instance has its own behavioural RAM. A reference model
// (golden memory, pending-read record, grant rules from the arbitration
// policy) predicts every output each cycle for both instances.
// -----------------------------------------------------------------------------
module tb_onchip_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [11:0] r0_address, r1_address;
  logic [3:0]  r0_byteenable, r1_byteenable;
  logic        r0_read, r0_write, r1_read, r1_write;
  logic [31:0] r0_writedata, r1_writedata;

  // Observed outputs, index 0 = round-robin, 1 = priority
  logic        o_w0 [2];
  logic        o_w1 [2];
  logic        o_v0 [2];
  logic        o_v1 [2];
  logic [31:0] o_rd0 [2];
  logic [31:0] o_rd1 [2];
  logic        o_cs [2];
  logic        o_we [2];
  logic [11:0] o_addr [2];
  logic [3:0]  o_be [2];
  logic [31:0] o_wd [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int k);
    return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [11:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] ram_q;
    logic [31:0] ram [4096];

    onchip_mem_arbiter #(
      .ADDR_W(12), .DATA_W(32), .PRIO_MODE(g), .STARVE_LIMIT(LIMIT)
    ) u_dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .r0_address       (r0_address),
      .r0_byteenable    (r0_byteenable),
      .r0_read          (r0_read),
      .r0_write         (r0_write),
      .r0_writedata     (r0_writedata),
      .r0_waitrequest   (o_w0[g]),
      .r0_readdata      (o_rd0[g]),
      .r0_readdatavalid (o_v0[g]),
      .r1_address       (r1_address),
      .r1_byteenable    (r1_byteenable),
      .r1_read          (r1_read),
      .r1_write         (r1_write),
      .r1_writedata     (r1_writedata),
      .r1_waitrequest   (o_w1[g]),
      .r1_readdata      (o_rd1[g]),
      .r1_readdatavalid (o_v1[g]),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_writedata    (mem_writedata),
      .mem_readdata     (ram_q)
    );

    initial for (int k = 0; k < 4096; k++) ram[k] <= init_word(k);

    // Single-port RAM, one-cycle read latency, byte-lane writes
    always @(posedge clk) begin
      if (mem_chipselect) begin
        if (mem_write) begin
          for (int b = 0; b < 4; b++)
            if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end else begin
          ram_q <= ram[mem_address];
        end
      end
    end

    assign o_cs[g]   = mem_chipselect;
    assign o_we[g]   = mem_write;
    assign o_addr[g] = mem_address;
    assign o_be[g]   = mem_byteenable;
    assign o_wd[g]   = mem_writedata;
  end

  // ---------------------------------------------------------------------------
  // Reference model state (per instance)
  // ---------------------------------------------------------------------------
  logic [31:0] gold [2][4096];
  bit          m_ready [2];
  int          m_last [2];
  int          m_starve [2];
  bit          m_pend [2];
  int          m_owner [2];
  logic [31:0] m_pdata [2];

  // Last observed values, for the directed checks
  int          obs_gnt [2];
  logic        obs_v0 [2];
  logic        obs_v1 [2];
  logic [31:0] obs_rd0 [2];
  logic [31:0] obs_rd1 [2];
  logic        obs_we [2];

  function automatic string tg(string s, int i);
    return $sformatf("%s[%s]", s, (i == 0) ? "rr" : "prio");
  endfunction

  // Winner of a cycle: -1 none, 0 r0, 1 r1
  function automatic int pick(int mode, bit q0, bit q1, int last, int starve);
    if (!q0 && !q1) return -1;
    if (q0 && !q1)  return 0;
    if (q1 && !q0)  return 1;
    if (mode == 0)  return (last == 0) ? 1 : 0;
    return (starve == LIMIT) ? 1 : 0;
  endfunction

  task automatic model_reset(int i);
    m_ready[i]  = 1'b0;
    m_last[i]   = 1;
    m_starve[i] = 0;
    m_pend[i]   = 1'b0;
    m_owner[i]  = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare at the falling edge, advance the model, then
  // return just after the rising edge so the caller can change inputs.
  task automatic cycle();
    int          w;
    bit          q0, q1, wr, rd;
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
    @(negedge clk);
    q0 = r0_read | r0_write;
    q1 = r1_read | r1_write;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) model_reset(i);
      w = m_ready[i] ? pick(i, q0, q1, m_last[i], m_starve[i]) : -1;
      wr = (w == 0) ? r0_write : (w == 1) ? r1_write : 1'b0;
      rd = (w == 0) ? r0_read  : (w == 1) ? r1_read  : 1'b0;
      a  = (w == 1) ? r1_address    : r0_address;
      be = (w == 1) ? r1_byteenable : r0_byteenable;
      wd = (w == 1) ? r1_writedata  : r0_writedata;

      check(tg("r0_waitrequest", i), 32'(o_w0[i]), 32'(w != 0));
      check(tg("r1_waitrequest", i), 32'(o_w1[i]), 32'(w != 1));
      check(tg("mem_chipselect", i), 32'(o_cs[i]), 32'(w >= 0));
      check(tg("mem_write", i),      32'(o_we[i]), 32'(wr));
      if (w >= 0) begin
        check(tg("mem_address", i),    32'(o_addr[i]), 32'(a));
        check(tg("mem_byteenable", i), 32'(o_be[i]),   32'(be));
        if (wr) check(tg("mem_writedata", i), o_wd[i], wd);
      end
      check(tg("r0_readdatavalid", i), 32'(o_v0[i]), 32'(m_pend[i] && m_owner[i] == 0));
      check(tg("r1_readdatavalid", i), 32'(o_v1[i]), 32'(m_pend[i] && m_owner[i] == 1));
      if (m_pend[i] && m_owner[i] == 0) check(tg("r0_readdata", i), o_rd0[i], m_pdata[i]);
      if (m_pend[i] && m_owner[i] == 1) check(tg("r1_readdata", i), o_rd1[i], m_pdata[i]);

      obs_gnt[i] = !o_w0[i] ? 0 : (!o_w1[i] ? 1 : -1);
      obs_v0[i]  = o_v0[i];
      obs_v1[i]  = o_v1[i];
      obs_rd0[i] = o_rd0[i];
      obs_rd1[i] = o_rd1[i];
      obs_we[i]  = o_we[i];

      if (reset_n) begin
        if (!q1 || w == 1)                  m_starve[i] = 0;
        else if (w == 0 && m_starve[i] < LIMIT) m_starve[i]++;
        m_pend[i] = 1'b0;
        if (w >= 0) begin
          m_last[i] = w;
          if (wr) begin
            for (int b = 0; b < 4; b++)
              if (be[b]) gold[i][a][8*b +: 8] = wd[8*b +: 8];
          end else if (rd) begin
            m_pend[i]  = 1'b1;
            m_owner[i] = w;
            m_pdata[i] = gold[i][a];
          end
        end
        m_ready[i] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    r0_read = 1'b0; r0_write = 1'b0;
    r1_read = 1'b0; r1_write = 1'b0;
  endtask

  int exp_prio_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int seq_rr [10];
  int seq_pr [10];
  int nv0 [2];
  int nv1 [2];

  initial begin
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4096; k++) gold[i][k] = init_word(k);
    for (int i = 0; i < 2; i++) model_reset(i);

    reset_n       = 1'b0;
    idle();
    r0_address    = 12'h010; r0_byteenable = 4'hF; r0_writedata = '0;
    r1_address    = 12'h000; r1_byteenable = 4'hF; r1_writedata = '0;
    r0_read       = 1'b1;

    // Reset release with r0 already requesting
    repeat (3) cycle();
    reset_n = 1'b1;
    cycle();
    check("blank_no_grant", 32'(obs_gnt[0]), 32'(-1));
    cycle();
    check("first_grant_r0", 32'(obs_gnt[0]), 32'(0));
    r0_read = 1'b0;
    cycle();
    check("first_read_valid", 32'(obs_v0[0]), 32'(1));
    check("first_read_data",  obs_rd0[0], init_word(16));

    // r1 write then read
    r1_address = 12'h123; r1_writedata = 32'hDEAD_BEEF; r1_byteenable = 4'hF;
    r1_write = 1'b1;
    cycle();
    check("r1_write_grant", 32'(obs_gnt[1]), 32'(1));
    r1_write = 1'b0; r1_read = 1'b1;
    cycle();
    check("r1_read_grant", 32'(obs_gnt[1]), 32'(1));
    idle();
    cycle();
    check("r1_read_valid", 32'(obs_v1[1]), 32'(1));
    check("r1_read_data",  obs_rd1[1], 32'hDEAD_BEEF);
    check("r0_no_valid",   32'(obs_v0[1]), 32'(0));

    // Byte-lane write
    r0_address = 12'h040; r0_writedata = 32'h1122_3344; r0_byteenable = 4'hF;
    r0_write = 1'b1;
    cycle();
    r0_writedata = 32'h0000_AA00; r0_byteenable = 4'b0010;
    cycle();
    r0_write = 1'b0; r0_read = 1'b1; r0_byteenable = 4'hF;
    cycle();
    idle();
    cycle();
    check("byte_lane_merge", obs_rd0[0], 32'h1122_AA44);

    // Continuous contention
    cycle();
    r0_address = 12'h000; r1_address = 12'h001;
    r0_read = 1'b1; r1_read = 1'b1;
    nv0 = '{0, 0}; nv1 = '{0, 0};
    for (int k = 0; k < 10; k++) begin
      cycle();
      seq_rr[k] = obs_gnt[0];
      seq_pr[k] = obs_gnt[1];
      for (int i = 0; i < 2; i++) begin nv0[i] += int'(obs_v0[i]); nv1[i] += int'(obs_v1[i]); end
    end
    idle();
    cycle();
    for (int i = 0; i < 2; i++) begin nv0[i] += int'(obs_v0[i]); nv1[i] += int'(obs_v1[i]); end
    for (int k = 1; k < 10; k++)
      check($sformatf("rr_alternate_%0d", k), 32'(seq_rr[k] != seq_rr[k-1]), 32'(1));
    for (int k = 0; k < 10; k++)
      check($sformatf("prio_seq_%0d", k), 32'(seq_pr[k]), 32'(exp_prio_seq[k]));
    check("rr_r0_returns",   32'(nv0[0]), 32'(5));
    check("rr_r1_returns",   32'(nv1[0]), 32'(5));
    check("prio_r0_returns", 32'(nv0[1]), 32'(8));
    check("prio_r1_returns", 32'(nv1[1]), 32'(2));

    // Read and write together: treated as a write
    r0_address = 12'h050; r0_writedata = 32'hCAFE_F00D; r0_byteenable = 4'hF;
    r0_read = 1'b1; r0_write = 1'b1;
    cycle();
    check("rw_is_write", 32'(obs_we[0]), 32'(1));
    idle();
    cycle();
    check("rw_no_valid", 32'(obs_v0[0]), 32'(0));

    // Read in flight killed by reset
    r0_read = 1'b1;
    cycle();
    check("kill_read_grant", 32'(obs_gnt[0]), 32'(0));
    reset_n = 1'b0;
    idle();
    cycle();
    check("killed_read_valid_rr",   32'(obs_v0[0]), 32'(0));
    check("killed_read_valid_prio", 32'(obs_v0[1]), 32'(0));
    cycle();
    reset_n = 1'b1;
    cycle();
    cycle();

    // Randomized traffic over a small address window
    for (int k = 0; k < 400; k++) begin
      r0_read       = ($urandom_range(0, 99) < 45);
      r0_write      = ($urandom_range(0, 99) < 25);
      r1_read       = ($urandom_range(0, 99) < 40);
      r1_write      = ($urandom_range(0, 99) < 25);
      r0_address    = ($urandom_range(0, 19) == 0) ? 12'hFFF : 12'($urandom_range(0, 15));
      r1_address    = 12'($urandom_range(0, 15));
      r0_byteenable = 4'($urandom_range(0, 15));
      r1_byteenable = 4'($urandom_range(0, 15));
      r0_writedata  = $urandom;
      r1_writedata  = $urandom;
      cycle();
    end
    idle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
